// File: rtl/vfifo_line_writer.sv
// ---------------------------------------------------------------------------
// vfifo_line_writer
//   Pops {seg-x, line-y, pixel} words from a first-word-fall-through pixel
//   FIFO and writes the pixels into a two-bank line buffer (bank = y[0]).
//   A bank is flagged to the display reader only once both half-line segments
//   of the same line have been written completely. The FIFO is stalled while
//   the bank addressed by the head word is still held by the reader.
//
// Ports
//   clk125, sys_rst_n          clock, async active-low reset
//   fifo_dout/fifo_empty       FWFT FIFO head {rsv, x, y[10:0], pixel[15:0]}
//   fifo_rd_en                 pop strobe (combinational)
//   lb_wr_en/bank/addr/data    registered line buffer write port
//   line_ready[1:0]            bank holds a complete line, owned by reader
//   line_y0/line_y1            line number held in bank 0/1
//   line_release[1:0]          reader pulse: bank consumed
//   drop_cnt/seg_err_cnt       saturating error counters
// ---------------------------------------------------------------------------
module vfifo_line_writer #(
  parameter int SEG_PIXELS  = 640,
  parameter int LINE_PIXELS = 2*SEG_PIXELS,
  parameter int CNT_W       = 16
) (
  input  logic                              clk125,
  input  logic                              sys_rst_n,
  input  logic [28:0]                       fifo_dout,
  input  logic                              fifo_empty,
  output logic                              fifo_rd_en,
  output logic                              lb_wr_en,
  output logic                              lb_wr_bank,
  output logic [$clog2(LINE_PIXELS)-1:0]    lb_wr_addr,
  output logic [15:0]                       lb_wr_data,
  output logic [1:0]                        line_ready,
  output logic [10:0]                       line_y0,
  output logic [10:0]                       line_y1,
  input  logic [1:0]                        line_release,
  output logic [CNT_W-1:0]                  drop_cnt,
  output logic [CNT_W-1:0]                  seg_err_cnt
);
  localparam int ADDR_W = $clog2(LINE_PIXELS);
  localparam int PIX_W  = $clog2(SEG_PIXELS+1);
  localparam int CW1    = CNT_W + 1;

  typedef enum logic {S_IDLE, S_FILL} state_e;

  state_e              state_q;
  logic                cur_x_q;
  logic [10:0]         cur_y_q;
  logic [PIX_W-1:0]    pix_cnt_q;
  logic [1:0]          seg_done_q, seg_done_d;
  logic [10:0]         seg_y_q, seg_y_d;
  logic [1:0]          line_ready_q, line_ready_d;
  logic [10:0]         line_y0_q, line_y1_q;
  logic [CNT_W-1:0]    drop_q, drop_d, err_q, err_d;
  logic                wr_en_q, wr_bank_q;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [15:0]         wr_data_q;

  logic                w_rsv, w_x;
  logic [10:0]         w_y;
  logic                same_key, in_rng, last, acc, wr, drop, fin;
  logic                err_seg, err_line, done_set;
  logic [1:0]          done_base, err_inc;
  logic [CW1-1:0]      err_sum;

  assign fifo_rd_en = sys_rst_n & ~fifo_empty & ~line_ready_q[fifo_dout[16]];

  always_comb begin
    w_rsv     = fifo_dout[28];
    w_x       = fifo_dout[27];
    w_y       = fifo_dout[26:16];
    // A word for the segment already open continues at pix_cnt; anything
    // else restarts at index 0. After a completed segment pix_cnt sits at
    // SEG_PIXELS, so extra words of that segment fall out as overlong.
    same_key  = (w_x == cur_x_q) && (w_y == cur_y_q);
    in_rng    = same_key ? (pix_cnt_q < PIX_W'(SEG_PIXELS)) : 1'b1;
    last      = same_key ? (pix_cnt_q == PIX_W'(SEG_PIXELS-1)) : (SEG_PIXELS == 1);
    acc       = fifo_rd_en & ~w_rsv;
    wr        = acc & in_rng;
    drop      = fifo_rd_en & (w_rsv | ~in_rng);
    done_set  = wr & last;
    // Both halves present: this cycle hands the bank over, so the mask no
    // longer counts as a pending partial line.
    fin       = &seg_done_q;
    done_base = fin ? 2'b00 : seg_done_q;
    err_seg   = acc & ~same_key & (state_q == S_FILL);
    err_line  = acc & (done_base != 2'b00) & (w_y != seg_y_q);

    seg_done_d = err_line ? 2'b00 : done_base;
    if (done_set) seg_done_d[w_x] = 1'b1;
    seg_y_d    = done_set ? w_y : seg_y_q;

    // Release first so a same-cycle set on that bank wins.
    line_ready_d = line_ready_q & ~line_release;
    if (fin) line_ready_d[seg_y_q[0]] = 1'b1;

    wr_addr_d = (same_key ? ADDR_W'(pix_cnt_q) : '0) +
                (w_x ? ADDR_W'(SEG_PIXELS) : '0);

    err_inc = {1'b0, err_seg} + {1'b0, err_line};
    err_sum = {1'b0, err_q} + CW1'(err_inc);
    err_d   = err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
    drop_d  = (drop && (drop_q != '1)) ? drop_q + CNT_W'(1) : drop_q;
  end

  always_ff @(posedge clk125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      cur_x_q      <= 1'b0;
      cur_y_q      <= '0;
      pix_cnt_q    <= '0;
      seg_done_q   <= 2'b00;
      seg_y_q      <= '0;
      line_ready_q <= 2'b00;
      line_y0_q    <= '0;
      line_y1_q    <= '0;
      drop_q       <= '0;
      err_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_bank_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_en_q <= wr;
      if (wr) begin
        wr_bank_q <= w_y[0];
        wr_addr_q <= wr_addr_d;
        wr_data_q <= fifo_dout[15:0];
        pix_cnt_q <= (same_key ? pix_cnt_q : '0) + PIX_W'(1);
        state_q   <= last ? S_IDLE : S_FILL;
      end
      if (acc) begin
        cur_x_q <= w_x;
        cur_y_q <= w_y;
      end
      seg_done_q   <= seg_done_d;
      seg_y_q      <= seg_y_d;
      line_ready_q <= line_ready_d;
      if (fin && !seg_y_q[0]) line_y0_q <= seg_y_q;
      if (fin &&  seg_y_q[0]) line_y1_q <= seg_y_q;
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

  assign lb_wr_en    = wr_en_q;
  assign lb_wr_bank  = wr_bank_q;
  assign lb_wr_addr  = wr_addr_q;
  assign lb_wr_data  = wr_data_q;
  assign line_ready  = line_ready_q;
  assign line_y0     = line_y0_q;
  assign line_y1     = line_y1_q;
  assign drop_cnt    = drop_q;
  assign seg_err_cnt = err_q;
endmodule

// File: tb/tb_vfifo_line_writer.sv
// Randomised bench for vfifo_line_writer. A word-level reference model
// tracks segments, completed halves, bank ownership and counters; DUT
// outputs are compared each cycle on the falling edge.
module tb_vfifo_line_writer;
  localparam int SEG = 640;

  logic        clk125 = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [28:0] fifo_dout = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic        lb_wr_en, lb_wr_bank;
  logic [10:0] lb_wr_addr;
  logic [15:0] lb_wr_data;
  logic [1:0]  line_ready;
  logic [10:0] line_y0, line_y1;
  logic [1:0]  line_release = 2'b00;
  logic [15:0] drop_cnt, seg_err_cnt;

  always #4 clk125 = ~clk125;

  vfifo_line_writer #(.SEG_PIXELS(SEG), .LINE_PIXELS(2*SEG), .CNT_W(16)) dut (
    .clk125(clk125), .sys_rst_n(sys_rst_n),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .lb_wr_en(lb_wr_en), .lb_wr_bank(lb_wr_bank), .lb_wr_addr(lb_wr_addr),
    .lb_wr_data(lb_wr_data), .line_ready(line_ready), .line_y0(line_y0),
    .line_y1(line_y1), .line_release(line_release),
    .drop_cnt(drop_cnt), .seg_err_cnt(seg_err_cnt));

  int n_chk = 0, n_fail = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
    end
  endtask

  // FIFO contents
  logic [28:0] q[$];

  // Reference model state
  int       m_cx, m_cy, m_cnt, m_sy, m_drop, m_err;
  bit       m_fill;
  bit [1:0] m_done, m_rdy;
  int       m_ly[2];
  bit       e_we, e_bank;
  int       e_addr, e_data;

  function automatic int sat(int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic void model_reset();
    m_cx = 0; m_cy = 0; m_cnt = 0; m_sy = 0; m_drop = 0; m_err = 0;
    m_fill = 0; m_done = 0; m_rdy = 0; m_ly[0] = 0; m_ly[1] = 0;
    e_we = 0; e_bank = 0; e_addr = 0; e_data = 0;
  endfunction

  // One clock edge worth of behaviour, computed per popped word.
  function automatic void model_step(bit pop, logic [28:0] w, logic [1:0] rel);
    int x, y, nerr;
    e_we = 0; nerr = 0;
    for (int b = 0; b < 2; b++) if (rel[b]) m_rdy[b] = 0;
    if (m_done == 2'b11) begin
      m_rdy[m_sy[0]] = 1; m_ly[m_sy[0]] = m_sy; m_done = 0;
    end
    if (pop && w[28]) m_drop = sat(m_drop + 1);
    else if (pop) begin
      x = int'(w[27]); y = int'(w[26:16]);
      if (m_done != 0 && y != m_sy) begin nerr++; m_done = 0; end
      if (x != m_cx || y != m_cy) begin
        if (m_fill) nerr++;
        m_cx = x; m_cy = y; m_cnt = 0;
      end
      if (m_cnt < SEG) begin
        e_we = 1; e_bank = y[0]; e_addr = x*SEG + m_cnt; e_data = int'(w[15:0]);
        m_cnt++;
        m_fill = (m_cnt < SEG);
        if (m_cnt == SEG) begin m_done[x] = 1; m_sy = y; end
      end else m_drop = sat(m_drop + 1);
      m_err = sat(m_err + nerr);
    end
  endfunction

  task automatic push_seg(int x, int y, int n, bit rsv_ok);
    for (int i = 0; i < n; i++) begin
      if (rsv_ok && $urandom_range(0, 199) == 0) q.push_back({1'b1, 28'($urandom)});
      q.push_back({1'b0, 1'(x), 11'(y), 16'($urandom)});
    end
  endtask

  // Entered and left on a falling edge.
  task automatic cycle();
    logic [28:0] w;
    logic [1:0]  rel;
    bit          emp, pop;
    chk("wr_en", 32'(lb_wr_en), 32'(e_we));
    if (e_we && lb_wr_en === 1'b1) begin
      chk("wr_bank", 32'(lb_wr_bank), 32'(e_bank));
      chk("wr_addr", 32'(lb_wr_addr), 32'(e_addr));
      chk("wr_data", 32'(lb_wr_data), 32'(e_data));
    end
    chk("line_ready", 32'(line_ready), 32'(m_rdy));
    chk("line_y0", 32'(line_y0), 32'(m_ly[0]));
    chk("line_y1", 32'(line_y1), 32'(m_ly[1]));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("seg_err_cnt", 32'(seg_err_cnt), 32'(m_err));
    emp = (q.size() == 0) || ($urandom_range(0, 3) == 0);
    w   = (q.size() != 0) ? q[0] : 29'($urandom);
    for (int b = 0; b < 2; b++)
      rel[b] = m_rdy[b] ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 99) == 0);
    fifo_empty = emp; fifo_dout = w; line_release = rel;
    #1;
    pop = !emp && !m_rdy[w[16]];
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(pop));
    if (pop) void'(q.pop_front());
    model_step(pop, w, rel);
    @(posedge clk125);
    @(negedge clk125);
  endtask

  task automatic run_drain(int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin cycle(); n++; end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    repeat (4) cycle();
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 0);
    chk({tag, "_wr_en"}, 32'(lb_wr_en), 0);
    chk({tag, "_wr_bank"}, 32'(lb_wr_bank), 0);
    chk({tag, "_wr_addr"}, 32'(lb_wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(lb_wr_data), 0);
    chk({tag, "_ready"}, 32'(line_ready), 0);
    chk({tag, "_y0"}, 32'(line_y0), 0);
    chk({tag, "_y1"}, 32'(line_y1), 0);
    chk({tag, "_drop"}, 32'(drop_cnt), 0);
    chk({tag, "_err"}, 32'(seg_err_cnt), 0);
  endtask

  initial begin
    int x, y, n;
    model_reset();
    fifo_empty = 1'b0;
    repeat (3) @(negedge clk125);
    chk_all_zero("rst");
    sys_rst_n = 1'b1;
    fifo_empty = 1'b1;

    // Full line, stall on held bank, partial segment, overlong, reserved word
    push_seg(0, 5, SEG, 0); push_seg(1, 5, SEG, 0);
    push_seg(0, 7, SEG, 0); push_seg(1, 7, SEG, 0);
    push_seg(0, 4, 100, 0); push_seg(1, 4, SEG, 0);
    push_seg(0, 2, SEG + 5, 0);
    push_seg(0, 3, 50, 0);
    q.push_back({1'b1, 28'($urandom)});
    push_seg(0, 3, SEG - 50, 0); push_seg(1, 3, SEG, 0);
    run_drain(30000);

    // Reset in the middle of a line, then a clean line
    push_seg(0, 8, 300, 0);
    run_drain(2000);
    #2;
    fifo_empty = 1'b0; line_release = 2'b00;
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(negedge clk125); @(negedge clk125);
    sys_rst_n = 1'b1;
    fifo_empty = 1'b1;
    push_seg(0, 9, SEG, 0); push_seg(1, 9, SEG, 0);
    run_drain(5000);
    chk("line9_ready1", 32'(line_ready[1] | (m_rdy[1] ^ 1'b1)), 32'(1));

    // Random segment mix over a few lines
    for (int s = 0; s < 16; s++) begin
      y = $urandom_range(10, 13);
      x = $urandom_range(0, 1);
      n = ($urandom_range(0, 9) < 7) ? SEG : $urandom_range(1, SEG + 12);
      push_seg(x, y, n, 1);
    end
    run_drain(40000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
